// File: rtl/rcg_pkg.sv
// Shared types and defaults for the RCG controller: sequencer state encoding,
// PLL pin bundle and default cycle counts.
package rcg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWRUP     = 3'd1,
    ST_RESET     = 3'd2,
    ST_LOCK_WAIT = 3'd3,
    ST_SWITCH    = 3'd4,
    ST_RUN       = 3'd5,
    ST_RELOCK    = 3'd6,
    ST_FAIL      = 3'd7
  } seq_state_e;

  typedef struct packed {
    logic pd;
    logic rst_n;
    logic bypass;
  } pll_pins_t;

  localparam int unsigned DEF_PWRUP_CYC       = 64;
  localparam int unsigned DEF_RST_CYC         = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYC = 256;
  localparam int unsigned DEF_LOCK_TO_CYC     = 65535;
  localparam int unsigned DEF_SWITCH_CYC      = 8;
  localparam int unsigned DEF_CNT_W           = 16;

  localparam pll_pins_t PINS_RESET = '{pd: 1'b1, rst_n: 1'b0, bypass: 1'b1};
  localparam pll_pins_t PINS_SCAN  = '{pd: 1'b0, rst_n: 1'b1, bypass: 1'b1};

  function automatic pll_pins_t state_pins(input seq_state_e st);
    pll_pins_t p;
    case (st)
      ST_PWRUP, ST_RESET:     p = '{pd: 1'b0, rst_n: 1'b0, bypass: 1'b1};
      ST_LOCK_WAIT, ST_RELOCK: p = '{pd: 1'b0, rst_n: 1'b1, bypass: 1'b1};
      ST_SWITCH, ST_RUN:      p = '{pd: 1'b0, rst_n: 1'b1, bypass: 1'b0};
      default:                p = PINS_RESET;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rcg_sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module rcg_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  // NOTE: flops are written with <= so every stage samples the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/rcg_ctrl_pll_seq.sv
// PLL power-up / lock / bypass-release sequencer running on the reference clock.
// Outputs are registered from the state register; scan forces safe pin values.
module rcg_ctrl_pll_seq
  import rcg_pkg::*;
#(
  parameter int unsigned PWRUP_CYC       = DEF_PWRUP_CYC,
  parameter int unsigned RST_CYC         = DEF_RST_CYC,
  parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int unsigned LOCK_TO_CYC     = DEF_LOCK_TO_CYC,
  parameter int unsigned SWITCH_CYC      = DEF_SWITCH_CYC,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic       ref_clk,
  input  logic       hgrst_n,
  input  logic       scan_mode,
  input  logic       pll_en_r,
  input  logic       pll_relock_en_r,
  input  logic       lock_lost_clr,
  input  logic       pll_lock,
  output logic       pll_pd,
  output logic       pll_rst_n,
  output logic       pll_bypass_r,
  output logic [2:0] seq_state,
  output logic       pll_lock_lost,
  output logic       pll_fail
);

  localparam logic [CNT_W-1:0] PWRUP_LD  = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LD = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LD     = CNT_W'(LOCK_TO_CYC - 1);
  localparam logic [CNT_W-1:0] SWITCH_LD = CNT_W'(SWITCH_CYC - 1);

  logic             lock_s;
  seq_state_e       state_q, state_d, seq_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic [CNT_W-1:0] tmo_q, tmo_d, tmo_dec;
  pll_pins_t        pins_q;
  logic             lost_q, lost_d, lost_set;
  logic             fail_q, fail_d, fail_set;
  logic             clr_ok;

  rcg_sync2 u_lock_sync (
    .clk   (ref_clk),
    .rst_n (hgrst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
  assign tmo_dec = (tmo_q == '0) ? '0 : tmo_q - CNT_W'(1);
  assign clr_ok  = lock_lost_clr & ~scan_mode;

  // NOTE: every signal gets its default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    lost_set = 1'b0;
    fail_set = 1'b0;
    if (scan_mode) begin
      // FSM and counters frozen while scan shifts
    end else if (state_q != ST_IDLE && !pll_en_r) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (pll_en_r) begin
          state_d = ST_PWRUP;
          cnt_d   = PWRUP_LD;
        end
        ST_PWRUP: if (cnt_q == '0) begin
          state_d = ST_RESET;
          cnt_d   = RST_LD;
        end else cnt_d = cnt_dec;
        ST_RESET: if (cnt_q == '0) begin
          state_d = ST_LOCK_WAIT;
          cnt_d   = STABLE_LD;
          tmo_d   = TO_LD;
        end else cnt_d = cnt_dec;
        ST_LOCK_WAIT: begin
          // cnt tracks the stable-lock window, tmo the overall lock timeout
          if (lock_s && cnt_q == '0) begin
            state_d = ST_SWITCH;
            cnt_d   = SWITCH_LD;
          end else if (tmo_q == '0) begin
            state_d  = ST_FAIL;
            fail_set = 1'b1;
          end else begin
            tmo_d = tmo_dec;
            cnt_d = lock_s ? cnt_dec : STABLE_LD;
          end
        end
        ST_SWITCH: if (cnt_q == '0) state_d = ST_RUN;
                   else cnt_d = cnt_dec;
        ST_RUN: if (!lock_s) begin
          state_d  = ST_RELOCK;
          lost_set = 1'b1;
        end
        ST_RELOCK: if (pll_relock_en_r) begin
          state_d = ST_RESET;
          cnt_d   = RST_LD;
        end else state_d = ST_FAIL;
        ST_FAIL: state_d = ST_FAIL;
      endcase
    end
    lost_d = lost_set | (lost_q & ~clr_ok);
    fail_d = fail_set | (fail_q & ~clr_ok);
  end

  always_ff @(posedge ref_clk or negedge hgrst_n) begin
    if (!hgrst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      pins_q  <= PINS_RESET;
      seq_q   <= ST_IDLE;
      lost_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      pins_q  <= state_pins(state_q);
      seq_q   <= state_q;
      lost_q  <= lost_d;
      fail_q  <= fail_d;
    end
  end

  assign {pll_pd, pll_rst_n, pll_bypass_r} = scan_mode ? PINS_SCAN : pins_q;
  assign seq_state     = seq_q;
  assign pll_lock_lost = lost_q;
  assign pll_fail      = fail_q;

endmodule

// File: tb/tb_rcg_ctrl_pll_seq.sv
// Self-checking bench for rcg_ctrl_pll_seq: directed scenarios with literal
// timing expectations, then randomized stimulus against a behavioural model.
module tb_rcg_ctrl_pll_seq;

  localparam int PWRUP  = 4;
  localparam int RST    = 2;
  localparam int STABLE = 8;
  localparam int TO     = 40;
  localparam int SWITCH = 2;

  localparam int S_IDLE = 0, S_PWRUP = 1, S_RESET = 2, S_LOCKW = 3;
  localparam int S_SWITCH = 4, S_RUN = 5, S_RELOCK = 6, S_FAIL = 7;

  logic       ref_clk = 1'b0;
  logic       hgrst_n = 1'b0;
  logic       scan_mode = 1'b0;
  logic       pll_en_r = 1'b0;
  logic       pll_relock_en_r = 1'b1;
  logic       lock_lost_clr = 1'b0;
  logic       pll_lock = 1'b1;
  logic       pll_pd, pll_rst_n, pll_bypass_r;
  logic [2:0] seq_state;
  logic       pll_lock_lost, pll_fail;

  int checks = 0;
  int errors = 0;

  rcg_ctrl_pll_seq #(
    .PWRUP_CYC       (PWRUP),
    .RST_CYC         (RST),
    .LOCK_STABLE_CYC (STABLE),
    .LOCK_TO_CYC     (TO),
    .SWITCH_CYC      (SWITCH),
    .CNT_W           (16)
  ) dut (
    .ref_clk         (ref_clk),
    .hgrst_n         (hgrst_n),
    .scan_mode       (scan_mode),
    .pll_en_r        (pll_en_r),
    .pll_relock_en_r (pll_relock_en_r),
    .lock_lost_clr   (lock_lost_clr),
    .pll_lock        (pll_lock),
    .pll_pd          (pll_pd),
    .pll_rst_n       (pll_rst_n),
    .pll_bypass_r    (pll_bypass_r),
    .seq_state       (seq_state),
    .pll_lock_lost   (pll_lock_lost),
    .pll_fail        (pll_fail)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_st = S_IDLE, m_out_st = S_IDLE, m_el = 0, m_run = 0;
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_lost = 1'b0, m_fail = 1'b0;

  // pd / rst_n / bypass for each state, straight from the state table
  function automatic logic [2:0] exp_pins(input int st);
    case (st)
      S_PWRUP, S_RESET:  return 3'b001;
      S_LOCKW, S_RELOCK: return 3'b011;
      S_SWITCH, S_RUN:   return 3'b010;
      default:           return 3'b101;
    endcase
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_out_st = S_IDLE; m_el = 0; m_run = 0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_lost = 1'b0; m_fail = 1'b0;
  endtask

  task automatic model_step();
    logic ls, fset, lset;
    int   nxt;
    ls = m_s2; m_s2 = m_s1; m_s1 = pll_lock;
    m_out_st = m_st;
    if (!scan_mode) begin
      fset = 1'b0; lset = 1'b0; nxt = m_st;
      if (m_st != S_IDLE && !pll_en_r) nxt = S_IDLE;
      else begin
        case (m_st)
          S_IDLE:   if (pll_en_r) nxt = S_PWRUP;
          S_PWRUP:  if (m_el >= PWRUP - 1) nxt = S_RESET; else m_el++;
          S_RESET:  if (m_el >= RST - 1) nxt = S_LOCKW; else m_el++;
          S_LOCKW: begin
            if (ls && m_run >= STABLE - 1) nxt = S_SWITCH;
            else if (m_el >= TO - 1) begin nxt = S_FAIL; fset = 1'b1; end
            else begin m_el++; m_run = ls ? m_run + 1 : 0; end
          end
          S_SWITCH: if (m_el >= SWITCH - 1) nxt = S_RUN; else m_el++;
          S_RUN:    if (!ls) begin nxt = S_RELOCK; lset = 1'b1; end
          S_RELOCK: nxt = pll_relock_en_r ? S_RESET : S_FAIL;
          default:  nxt = m_st;
        endcase
      end
      if (nxt != m_st) begin m_el = 0; m_run = 0; end
      m_st = nxt;
      if (fset) m_fail = 1'b1; else if (lock_lost_clr) m_fail = 1'b0;
      if (lset) m_lost = 1'b1; else if (lock_lost_clr) m_lost = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge ref_clk or negedge hgrst_n);
      if (!hgrst_n) model_reset();
      else model_step();
    end
  end

  // compare process: every falling edge, away from the active edge
  initial begin
    logic [2:0] ep;
    forever begin
      @(negedge ref_clk);
      ep = scan_mode ? 3'b011 : exp_pins(m_out_st);
      check("pll_pd", pll_pd, ep[2]);
      check("pll_rst_n", pll_rst_n, ep[1]);
      check("pll_bypass_r", pll_bypass_r, ep[0]);
      check("seq_state", seq_state, m_out_st);
      check("pll_lock_lost", pll_lock_lost, m_lost);
      check("pll_fail", pll_fail, m_fail);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge ref_clk);
    @(negedge ref_clk);
    #1;
  endtask

  task automatic wait_seq(input logic [2:0] exp, input int max, input string name);
    int n = 0;
    while (seq_state !== exp && n < max) begin tick(); n++; end
    check(name, seq_state, exp);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("reset_pins", {pll_pd, pll_rst_n, pll_bypass_r}, 3'b101);
    check("reset_flags", {seq_state, pll_lock_lost, pll_fail}, 5'b0);
    hgrst_n = 1'b1;
    repeat (3) tick();

    // nominal bring-up, lock high throughout; edge 0 samples the enable
    pll_en_r = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      case (k)
        0:  check("nom_pd_c0", pll_pd, 1'b1);
        1:  check("nom_pd_c1", pll_pd, 1'b0);
        6:  check("nom_rst_c6", pll_rst_n, 1'b0);
        7:  check("nom_rst_c7", pll_rst_n, 1'b1);
        14: check("nom_byp_c14", pll_bypass_r, 1'b1);
        15: check("nom_byp_c15", pll_bypass_r, 1'b0);
        16: check("nom_seq_c16", seq_state, 3'd4);
        17: check("nom_seq_c17", seq_state, 3'd5);
        default: ;
      endcase
    end
    repeat (2) tick();

    // loss of lock for 3 cycles with relock enabled
    pll_lock = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 3) begin
        check("lol_byp_t3", pll_bypass_r, 1'b0);
        pll_lock = 1'b1;
      end
      if (t == 4) check("lol_byp_t4", {pll_bypass_r, pll_lock_lost}, 2'b11);
      if (t == 5 || t == 6) check("lol_rst_low", pll_rst_n, 1'b0);
      if (t == 7) check("lol_rst_high", pll_rst_n, 1'b1);
    end
    wait_seq(3'd5, 40, "relock_run");
    repeat (2) tick();

    // asynchronous reset mid-RUN with lock_lost still set
    hgrst_n = 1'b0;
    #1;
    check("hgrst_pins", {pll_pd, pll_rst_n, pll_bypass_r}, 3'b101);
    check("hgrst_state", {seq_state, pll_lock_lost, pll_fail}, 5'b0);
    tick();
    hgrst_n = 1'b1;
    wait_seq(3'd5, 40, "post_rst_run");

    // same drop with relock disabled
    pll_relock_en_r = 1'b0;
    pll_lock = 1'b0;
    repeat (3) tick();
    pll_lock = 1'b1;
    wait_seq(3'd7, 10, "norelock_fail");
    check("norelock_pd", {pll_pd, pll_lock_lost}, 2'b11);
    pll_en_r = 1'b0;
    wait_seq(3'd0, 4, "norelock_idle");
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    check("lost_clr", pll_lock_lost, 1'b0);
    pll_relock_en_r = 1'b1;

    // lock timeout
    pll_lock = 1'b0;
    repeat (3) tick();
    pll_en_r = 1'b1;
    for (int k = 0; k < 48; k++) begin
      tick();
      if (k == 45) check("to_fail_c45", pll_fail, 1'b0);
      if (k == 46) check("to_fail_c46", pll_fail, 1'b1);
      if (k == 47) check("to_seq_c47", seq_state, 3'd7);
    end
    pll_en_r = 1'b0;
    repeat (2) tick();
    check("to_idle_sticky", {seq_state, pll_fail}, {3'd0, 1'b1});
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    check("fail_clr", pll_fail, 1'b0);

    // lock chatter in LOCK_WAIT, then steady
    pll_en_r = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      pll_lock = ~pll_lock;
      repeat (5) tick();
    end
    pll_lock = 1'b1;
    n = 0;
    while (seq_state !== 3'd4 && n < 30) begin tick(); n++; end
    check("chatter_switch_lat", n, 11);
    wait_seq(3'd5, 10, "chatter_run");
    pll_en_r = 1'b0;
    repeat (2) tick();

    // scan pulse mid-PWRUP
    pll_en_r = 1'b1;
    repeat (2) tick();
    scan_mode = 1'b1;
    #1;
    check("scan_pins", {pll_pd, pll_rst_n, pll_bypass_r}, 3'b011);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("scan_seq_hold", seq_state, 3'd1);
    end
    scan_mode = 1'b0;
    wait_seq(3'd5, 40, "scan_resume_run");

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) pll_en_r = ~pll_en_r;
      if ($urandom_range(24) == 0) pll_lock = ~pll_lock;
      if ($urandom_range(49) == 0) pll_relock_en_r = ~pll_relock_en_r;
      lock_lost_clr = ($urandom_range(39) == 0);
      scan_mode = ($urandom_range(99) == 0);
      if (!pll_en_r && $urandom_range(9) == 0) pll_en_r = 1'b1;
      tick();
    end
    scan_mode = 1'b0;
    lock_lost_clr = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
